// File: rtl/prbs_pkg.sv
// Shared PRBS-4 definitions for the LFSR generator and checker, so taps and
// state encodings stay in one place.
package prbs_pkg;

  // Checker FSM encoding
  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } prbs_state_e;

  // x^4 + x^3 + 1: b[n] = b[n-3] ^ b[n-4]; history is {b[n-1],..,b[n-4]}
  localparam int unsigned LFSR_W = 4;
  localparam int unsigned TAP_A  = 1;
  localparam int unsigned TAP_B  = 0;
  localparam int unsigned PERIOD = 15;

  // Next sequence bit predicted from the history register
  function automatic logic prbs_next_bit(input logic [LFSR_W-1:0] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/prbs4_checker_if.sv
// Link-side bundle of the PRBS-4 checker: serial input plus status outputs.
interface prbs4_checker_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic                          bit_in;
  logic                          bit_valid;
  logic                          clr_cnt;
  logic                          locked;
  logic                          err_pulse;
  logic [CNT_W-1:0]              err_cnt;
  logic [prbs_pkg::LFSR_W-1:0]   lfsr_state;

  modport master (
    output bit_in, bit_valid, clr_cnt,
    input  locked, err_pulse, err_cnt, lfsr_state
  );

  modport slave (
    input  bit_in, bit_valid, clr_cnt,
    output locked, err_pulse, err_cnt, lfsr_state
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear on clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prbs4_checker.sv
// Self-synchronising PRBS-4 (x^4+x^3+1) checker: hunts for a non-zero
// history, verifies LOCK_CNT consecutive predictions, then flywheels on its
// own predictions and counts line errors.
module prbs4_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned UNLOCK_ERRS = 3,
  parameter int unsigned CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  prbs4_checker_if.slave      bus
);

  prbs_state_e        state;
  logic [LFSR_W-1:0]  hist;
  logic [2:0]         fill;
  logic [3:0]         match_cnt;
  logic [2:0]         miss_cnt;
  logic               locked;
  logic               err_pulse;
  logic [CNT_W-1:0]   err_cnt;

  logic               exp_bit;
  logic               mismatch;
  logic               err_inc;
  logic [LFSR_W-1:0]  hist_rx;
  logic [LFSR_W-1:0]  hist_fly;

  // Prediction and candidate next histories (received vs. flywheel)
  always_comb begin
    exp_bit  = prbs_next_bit(hist);
    mismatch = bus.bit_in ^ exp_bit;
    hist_rx  = {bus.bit_in, hist[LFSR_W-1:1]};
    hist_fly = {exp_bit, hist[LFSR_W-1:1]};
    err_inc  = bus.bit_valid && (state == StLocked) && mismatch;
  end

  // Hunt / verify / locked sequencing with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StHunt;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_inc;
      if (bus.bit_valid) begin
        case (state)
          StHunt: begin
            hist <= hist_rx;
            if (fill != 3'(LFSR_W)) fill <= fill + 3'd1;
            // fill reaches LFSR_W on this bit (or already has); an all-zero
            // load keeps hunting until a one arrives
            if ((fill >= 3'(LFSR_W - 1)) && (hist_rx != '0)) begin
              state     <= StVerify;
              match_cnt <= '0;
            end
          end
          StVerify: begin
            hist <= hist_rx;
            if (hist_rx == '0) begin
              state     <= StHunt;
              fill      <= '0;
              match_cnt <= '0;
            end else if (!mismatch) begin
              if (match_cnt == 4'(LOCK_CNT - 1)) begin
                state     <= StLocked;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              // History already holds received bits, so just restart the run
              match_cnt <= '0;
            end
          end
          StLocked: begin
            // Flywheel: keep our own prediction so a line error cannot derail it
            hist <= hist_fly;
            if (mismatch) begin
              if (miss_cnt == 3'(UNLOCK_ERRS - 1)) begin
                state    <= StHunt;
                locked   <= 1'b0;
                fill     <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state  <= StHunt;
            locked <= 1'b0;
            fill   <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (bus.clr_cnt),
    .cnt (err_cnt)
  );

  assign bus.locked     = locked;
  assign bus.err_pulse  = err_pulse;
  assign bus.err_cnt    = err_cnt;
  assign bus.lfsr_state = hist;

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: two builds (default, and CNT_W=4/UNLOCK_ERRS=7)
// driven with the same stimulus and compared every cycle against a
// behavioural model of the hunt/verify/flywheel rules.
module tb_prbs4_checker;

  logic clk;
  logic rst;
  logic bit_in;
  logic bit_valid;
  logic clr_cnt;

  int n_cmp;
  int n_bad;

  prbs4_checker_if #(.CNT_W(16)) bus_a ();
  prbs4_checker_if #(.CNT_W(4))  bus_b ();

  assign bus_a.bit_in    = bit_in;
  assign bus_a.bit_valid = bit_valid;
  assign bus_a.clr_cnt   = clr_cnt;
  assign bus_b.bit_in    = bit_in;
  assign bus_b.bit_valid = bit_valid;
  assign bus_b.clr_cnt   = clr_cnt;

  prbs4_checker #(
    .LOCK_CNT    (8),
    .UNLOCK_ERRS (3),
    .CNT_W       (16)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  prbs4_checker #(
    .LOCK_CNT    (8),
    .UNLOCK_ERRS (7),
    .CNT_W       (4)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef enum int {MHunt, MVerify, MLocked} mmode_e;
  typedef struct {
    mmode_e mode;
    bit     b1, b2, b3, b4;  // b[n-1] .. b[n-4]
    int     fill;
    int     run;             // consecutive good predictions
    int     misses;          // consecutive errors while locked
    int     errs;
    bit     pulse;
  } mdl_t;

  mdl_t ma, mb;

  function automatic void mdl_reset(inout mdl_t m);
    m.mode = MHunt; m.b1 = 0; m.b2 = 0; m.b3 = 0; m.b4 = 0;
    m.fill = 0; m.run = 0; m.misses = 0; m.errs = 0; m.pulse = 0;
  endfunction

  function automatic void mdl_push(inout mdl_t m, input bit x);
    m.b4 = m.b3; m.b3 = m.b2; m.b2 = m.b1; m.b1 = x;
  endfunction

  function automatic void mdl_step(inout mdl_t m, input int lock_n, input int unlock_n,
                                   input int cnt_max, input bit b, input bit v, input bit c);
    bit e;
    m.pulse = 0;
    if (v) begin
      e = m.b3 ^ m.b4;
      case (m.mode)
        MHunt: begin
          mdl_push(m, b);
          if (m.fill < 4) m.fill++;
          if (m.fill == 4 && (m.b1 | m.b2 | m.b3 | m.b4)) begin
            m.mode = MVerify;
            m.run  = 0;
          end
        end
        MVerify: begin
          mdl_push(m, b);
          if (!(m.b1 | m.b2 | m.b3 | m.b4)) begin
            m.mode = MHunt; m.fill = 0; m.run = 0;
          end else if (b == e) begin
            m.run++;
            if (m.run == lock_n) begin
              m.mode = MLocked; m.run = 0; m.misses = 0;
            end
          end else begin
            m.run = 0;
          end
        end
        default: begin
          mdl_push(m, e);
          if (b != e) begin
            m.pulse = 1;
            if (m.errs < cnt_max) m.errs++;
            m.misses++;
            if (m.misses == unlock_n) begin
              m.mode = MHunt; m.fill = 0; m.misses = 0;
            end
          end else begin
            m.misses = 0;
          end
        end
      endcase
    end
    if (c) m.errs = 0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_all();
    check("a_locked", 32'(bus_a.locked), 32'(ma.mode == MLocked));
    check("a_pulse",  32'(bus_a.err_pulse), 32'(ma.pulse));
    check("a_cnt",    32'(bus_a.err_cnt), 32'(ma.errs));
    check("a_hist",   32'(bus_a.lfsr_state), 32'({ma.b1, ma.b2, ma.b3, ma.b4}));
    check("b_locked", 32'(bus_b.locked), 32'(mb.mode == MLocked));
    check("b_pulse",  32'(bus_b.err_pulse), 32'(mb.pulse));
    check("b_cnt",    32'(bus_b.err_cnt), 32'(mb.errs));
    check("b_hist",   32'(bus_b.lfsr_state), 32'({mb.b1, mb.b2, mb.b3, mb.b4}));
  endtask

  // ---------------- stimulus ----------------
  bit seq[15];
  int gi;

  function automatic bit gen_next();
    bit r;
    r  = seq[gi];
    gi = (gi + 1) % 15;
    return r;
  endfunction

  task automatic step(input bit b, input bit v, input bit c);
    bit_in = b; bit_valid = v; clr_cnt = c;
    @(posedge clk);
    mdl_step(ma, 8, 3, 65535, b, v, c);
    mdl_step(mb, 8, 7, 15, b, v, c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    mdl_reset(ma);
    mdl_reset(mb);
    check("rst_a_locked", 32'(bus_a.locked), 0);
    check("rst_a_cnt",    32'(bus_a.err_cnt), 0);
    check("rst_a_hist",   32'(bus_a.lfsr_state), 0);
    check("rst_b_locked", 32'(bus_b.locked), 0);
    check("rst_b_cnt",    32'(bus_b.err_cnt), 0);
    #2;
    rst = 1'b1;
  endtask

  // Clean bits from seed; checks lock appears exactly on the 12th valid bit
  task automatic clean_lock(input int nbits, input int max_gap);
    gi = 0;
    for (int k = 1; k <= nbits; k++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(1, max_gap);
        for (int j = 0; j < g; j++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      step(gen_next(), 1'b1, 1'b0);
      if (k == 11) check("lock_early", 32'(bus_a.locked), 0);
      if (k == 12) check("lock_at_12", 32'(bus_a.locked), 1);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int n = 0; n < 15; n++) seq[n] = (n == 3);
    for (int n = 4; n < 15; n++) seq[n] = seq[n-3] ^ seq[n-4];

    rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
    mdl_reset(ma); mdl_reset(mb);
    @(posedge clk); #1;
    check("rst_locked", 32'(bus_a.locked), 0);
    check("rst_pulse",  32'(bus_a.err_pulse), 0);
    check("rst_cnt",    32'(bus_a.err_cnt), 0);
    check("rst_hist",   32'(bus_a.lfsr_state), 0);
    #3; rst = 1'b1;

    // Clean lock over 100 bits
    clean_lock(100, 0);
    check("clean_no_err", 32'(bus_a.err_cnt), 0);

    // Single error while locked
    step(~gen_next(), 1'b1, 1'b0);
    check("single_pulse", 32'(bus_a.err_pulse), 1);
    check("single_cnt",   32'(bus_a.err_cnt), 1);
    for (int k = 0; k < 20; k++) step(gen_next(), 1'b1, 1'b0);
    check("single_still_locked", 32'(bus_a.locked), 1);
    check("single_cnt_after",    32'(bus_a.err_cnt), 1);

    // Burst of three errors unlocks build A only
    for (int k = 0; k < 3; k++) step(~gen_next(), 1'b1, 1'b0);
    check("burst_unlock", 32'(bus_a.locked), 0);
    check("burst_cnt",    32'(bus_a.err_cnt), 4);
    check("burst_b_hold", 32'(bus_b.locked), 1);
    for (int k = 1; k <= 12; k++) begin
      step(gen_next(), 1'b1, 1'b0);
      if (k == 11) check("relock_early", 32'(bus_a.locked), 0);
      if (k == 12) check("relock_at_12", 32'(bus_a.locked), 1);
    end

    // Isolated errors saturate the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      step(~gen_next(), 1'b1, 1'b0);
      step(gen_next(), 1'b1, 1'b0);
    end
    check("sat_b_cnt",    32'(bus_b.err_cnt), 15);
    check("sat_a_cnt",    32'(bus_a.err_cnt), 24);
    check("sat_a_locked", 32'(bus_a.locked), 1);

    // Clear wins over a simultaneous error
    step(~gen_next(), 1'b1, 1'b1);
    check("clr_a_cnt",  32'(bus_a.err_cnt), 0);
    check("clr_b_cnt",  32'(bus_b.err_cnt), 0);
    check("clr_pulse",  32'(bus_a.err_pulse), 1);

    // Async reset mid-LOCKED, then clean relock
    do_reset();
    clean_lock(20, 0);

    // All-zero input never locks
    do_reset();
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b0);
    check("zero_locked", 32'(bus_a.locked), 0);
    check("zero_cnt",    32'(bus_a.err_cnt), 0);
    check("zero_hist",   32'(bus_a.lfsr_state), 0);
    clean_lock(24, 0);

    // Gaps of invalid cycles: lock counts valid bits only
    do_reset();
    clean_lock(40, 5);
    check("gap_no_err", 32'(bus_a.err_cnt), 0);

    // Random soak: gaps, sparse errors, bursts, garbage spells, clears
    begin
      int burst_left;
      int garbage_left;
      burst_left = 0; garbage_left = 0;
      for (int k = 0; k < 3000; k++) begin
        bit v, e, c, b;
        v = ($urandom_range(0, 9) != 0);
        c = ($urandom_range(0, 99) == 0);
        e = ($urandom_range(0, 39) == 0);
        if (v && burst_left == 0 && $urandom_range(0, 149) == 0)
          burst_left = $urandom_range(1, 8);
        if (v && garbage_left == 0 && $urandom_range(0, 299) == 0)
          garbage_left = $urandom_range(5, 30);
        if (v) begin
          b = gen_next();
          if (burst_left > 0) begin e = 1; burst_left--; end
          if (garbage_left > 0) begin
            b = 1'($urandom_range(0, 1));
            e = 0;
            garbage_left--;
          end
          b = b ^ e;
        end else begin
          b = 1'($urandom_range(0, 1));
        end
        step(b, v, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs4_checker.md
Name: prbs4_checker

Overview:
- Receive-side companion of the team's 4-bit Fibonacci LFSR generator.
- Consumes the generator's serial output bit (state[0]), self-synchronises to the x^4+x^3+1 sequence and flags bit errors.
- Recurrence: b[n] = b[n-3] XOR b[n-4], period 15.
- Sits at the far end of the test link and feeds LEDs/counters on the FPGA board.

Parameters:
- LOCK_CNT, 8, consecutive correct predictions required to declare lock (range 1..15).
- UNLOCK_ERRS, 3, consecutive mismatches while locked that force re-hunt (range 1..7).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- bit_in  in  1  received serial bit
- bit_valid  in  1  bit_in is sampled on rising clk edges where bit_valid=1; ignored otherwise
- clr_cnt  in  1  synchronous clear of err_cnt
- locked  out  1  checker synchronised
- err_pulse  out  1  one-cycle pulse per detected bit error while locked
- err_cnt  out  CNT_W  saturating count of errors while locked
- lfsr_state  out  4  local history register {b[n-1],b[n-2],b[n-3],b[n-4]}

Behaviour:
- Reset (rst=0, async):
  - FSM=HUNT; hist=0, fill=0, match_cnt=0, miss_cnt=0.
  - locked=0, err_pulse=0, err_cnt=0, lfsr_state=0.
- All state updates occur only on valid cycles. Exceptions: err_pulse clears every cycle; clr_cnt acts every cycle.
- exp = hist[1] XOR hist[0] (b[n-3]^b[n-4]); compared against bit_in.
- FSM states:
  - HUNT: shift bit_in into hist (hist <= {bit_in, hist[3:1]}), fill++.
    - When fill reaches 4 with hist != 0, go to VERIFY with match_cnt=0.
    - If the 4 loaded bits are all zero, stay in HUNT with fill=4 and keep shifting; exit when hist becomes non-zero.
  - VERIFY: shift bit_in into hist.
    - bit_in==exp: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED and set locked=1 on that same edge.
    - Mismatch: match_cnt=0, stay in VERIFY. hist has already reloaded from received bits, so no separate re-hunt is needed.
    - If hist becomes all-zero, go to HUNT with fill=0.
  - LOCKED (flywheel): hist shifts in exp, not bit_in, so a single line error does not corrupt the prediction.
    - Match: miss_cnt=0.
    - Mismatch: err_pulse=1 on the next cycle, err_cnt++ (saturates at all-ones), miss_cnt++.
    - When miss_cnt reaches UNLOCK_ERRS, go to HUNT: locked=0, fill=0, miss_cnt=0. The error that triggers unlock is still counted and pulsed.
- Latency: err_pulse and err_cnt update on the clock edge that samples the errored bit, so they are visible one cycle after the bit is presented.
- err_pulse is never asserted outside LOCKED.
- clr_cnt together with a counted error in the same cycle: clear wins, err_cnt=0.
- bit_valid=0 cycles: hold all state; err_pulse=0.
- Reset asserted mid-operation: immediate return to reset values regardless of state.
- lfsr_state = hist at all times.

Decomposition:
- Shared package prbs_pkg:
  - FSM encodings HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2.
  - LFSR_W=4, TAP_A=1, TAP_B=0.
  - PERIOD=15.
  - Shared with the generator so the taps cannot diverge.
- One sub-module: sat_counter (CNT_W wide; inc, clr, clr priority, saturates at max).
- FSM and shift register stay in prbs4_checker.

Test Plan:
- Clean lock: drive the generator sequence from seed 4'b1000, i.e. bits 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 repeating, bit_valid=1.
  - Expect HUNT for 4 bits, then VERIFY; locked rises on the edge of bit 12 (4+8).
  - err_cnt=0 and err_pulse never asserted over 100 bits.
- Single error while locked: flip one bit after lock.
  - Expect exactly one err_pulse, err_cnt=1, locked stays 1.
  - The following bits produce no further errors (flywheel).
- Burst unlock: flip 3 consecutive bits while locked.
  - err_cnt=3; locked falls on the 3rd error edge; FSM=HUNT.
  - Clean data then relocks after 12 more valid bits.
- All-zero input: drive bit_in=0 for 40 valid cycles.
  - locked stays 0, FSM stays HUNT, err_cnt=0.
  - Then apply the clean sequence: lock is achieved.
- Gaps and clear: insert bit_valid=0 for random 1-5 cycle gaps during a clean sequence.
  - Lock timing counts valid bits only; no errors.
  - Assert clr_cnt in the same cycle as an errored bit: err_cnt=0.
  - Force err_cnt to all-ones (CNT_W=4 build, 20 errors with UNLOCK_ERRS=7 interleaved): holds at 15.
- Async reset mid-LOCKED: pull rst low between clock edges.
  - locked, err_cnt and lfsr_state go to 0 immediately, without a clock edge.
  - After release, behaviour matches the clean-lock scenario.
